mult_div_unit: RTL and testbench

//   Iterative HI/LO multiply/divide unit for the MIPS datapath (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between the datapath and the HI/LO multiply/divide unit.
// The master issues ops and MTHI/MTLO writes; the slave owns HI/LO and busy/done.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_value;
  logic [WIDTH-1:0] rt_value;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_value, rt_value, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_value, rt_value, mthi, mtlo,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide: radix-2 shift-add multiply, restoring divide,
// one bit per clock on sign-stripped magnitudes, with sign fixup in FINISH.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state, state_nx;
  logic [1:0]         op_q;
  logic               sign_a, sign_b, div0;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  // Issue-side operand conditioning: op[0]=0 selects the signed variants.
  logic             in_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign in_signed = ~bus.op[0];
  assign rs_neg    = in_signed & bus.rs_value[WIDTH-1];
  assign rt_neg    = in_signed & bus.rt_value[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_value : bus.rs_value;
  assign rt_mag    = rt_neg ? -bus.rt_value : bus.rt_value;

  // One iteration. Multiply: acc = {partial, multiplier}, add on LSB then shift
  // right. Divide: acc = {remainder, dividend/quotient}, shift left then trial subtract.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_sh   = {acc, 1'b0};
    div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, b_mag};
    acc_nx   = {mul_sum, acc[WIDTH-1:1]};
    if (op_q[1]) begin
      if (div_diff[WIDTH]) acc_nx = div_sh[2*WIDTH-1:0];
      else                 acc_nx = {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
    end
  end

  // Sign fixup applied when results are committed.
  logic               neg_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, hi_res, lo_res;

  always_comb begin
    neg_res = sign_a ^ sign_b;
    prod    = neg_res ? -acc : acc;
    quo     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem     = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_res  = prod[2*WIDTH-1:WIDTH];
    lo_res  = prod[WIDTH-1:0];
    if (op_q[1]) begin
      if (div0) begin
        // Divide by zero returns the dividend as issued and an all-ones quotient.
        hi_res = sign_a ? -a_mag : a_mag;
        lo_res = '1;
      end else begin
        hi_res = rem;
        lo_res = quo;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (count == CW'(WIDTH-1)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      count  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            sign_a <= rs_neg;
            sign_b <= rt_neg;
            div0   <= (bus.rt_value == '0);
            a_mag  <= rs_mag;
            b_mag  <= rt_mag;
            acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
            count  <= '0;
          end else begin
            if (bus.mthi) hi_q <= bus.rs_value;
            if (bus.mtlo) lo_q <= bus.rs_value;
          end
        end
        CALC: begin
          acc   <= acc_nx;
          count <= count + 1'b1;
        end
        FINISH: begin
          hi_q   <= hi_res;
          lo_q   <= lo_res;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table for op results and latency,
// plus hand sequences for MTHI/MTLO, ignored start/mthi while busy, and async reset abort.
module tb_mult_div_unit;
  localparam int W = 32;
  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(W)) bus();
  mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[16];

  // Issue an op at the next falling edge; E0 is the following rising edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_value = a; bus.rt_value = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Count busy cycles until done is seen; bounded so a stuck unit cannot hang the run.
  task automatic wait_done(output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
      if (bus.busy) busy_cyc++;
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int  cyc;
    bit  seen;
    issue(op, a, b);
    wait_done(cyc, seen);
    chk({tag, " done"}, 64'(seen), 64'd1);
    chk({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
    chk({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(bus.lo), 64'(elo));
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " hi_hold"}, 64'(bus.hi), 64'(ehi));
  endtask

  initial begin
    int  cyc;
    bit  seen;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{DIVU,  32'd20,       32'd3,        32'd2,        32'd6};
    vecs[5]  = '{DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[6]  = '{DIV,   32'd10,       32'd0,        32'd10,       32'hFFFFFFFF};
    vecs[7]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[8]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[9]  = '{DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
    vecs[10] = '{DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[11] = '{DIV,   32'hFFFFFFF6, 32'd0,        32'hFFFFFFF6, 32'hFFFFFFFF};
    vecs[12] = '{MULTU, 32'h12345678, 32'd0,        32'd0,        32'd0};
    vecs[13] = '{MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
    vecs[14] = '{MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
    vecs[15] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_value = '0; bus.rt_value = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset hi",   64'(bus.hi),   64'd0);
    chk("reset lo",   64'(bus.lo),   64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++)
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Idle MTLO, then both moves together.
    @(negedge clk);
    bus.mtlo = 1'b1; bus.rs_value = 32'd5;
    @(posedge clk);
    #1 bus.mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo lo",   64'(bus.lo),   64'd5);
    chk("mtlo hi",   64'(bus.hi),   64'd2);
    chk("mtlo done", 64'(bus.done), 64'd0);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.rs_value = 32'h0000ABCD;
    @(posedge clk);
    #1 begin bus.mthi = 1'b0; bus.mtlo = 1'b0; end
    @(negedge clk);
    chk("mthilo hi", 64'(bus.hi), 64'h0000ABCD);
    chk("mthilo lo", 64'(bus.lo), 64'h0000ABCD);

    // DIVU 20/3 with a stray start and mthi in cycle 10; hi/lo must hold until done.
    issue(DIVU, 32'd20, 32'd3);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.rs_value = 32'd9; bus.rt_value = 32'd9; bus.mthi = 1'b1;
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.mthi = 1'b0; end
    @(negedge clk);
    chk("busy_ign hi_hold", 64'(bus.hi),   64'h0000ABCD);
    chk("busy_ign busy",    64'(bus.busy), 64'd1);
    wait_done(cyc, seen);
    chk("busy_ign done",   64'(seen),   64'd1);
    chk("busy_ign hi",     64'(bus.hi), 64'd2);
    chk("busy_ign lo",     64'(bus.lo), 64'd6);
    @(negedge clk);
    chk("busy_ign idle",   64'(bus.busy), 64'd0);

    // Async reset in cycle 10 of a MULTU: outputs clear before any clock edge.
    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort hi",   64'(bus.hi),   64'd0);
    chk("abort lo",   64'(bus.lo),   64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort no_done", 64'(bus.done), 64'd0);
    run_check("post_reset", MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
